// File: rtl/keypad_column_scanner.sv
// +--------------------------------------------------------------------------+
// | keypad_column_scanner: 4x3 keypad column strobe, debounce and key report |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module keypad_column_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] R,
  output logic [2:0] C,
  output logic [3:0] N,
  output logic       V,
  input  logic       ack,
  output logic       ovr
);

  localparam int             DW          = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]  DWELL_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [3:0]     DB_MAX      = 4'(DEBOUNCE);
  // Result codes above the key range mark empty and ambiguous scans
  localparam logic [3:0]     RES_NONE    = 4'd12;
  localparam logic [3:0]     RES_INVALID = 4'd13;

  typedef enum logic [0:0] {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } state_e;

  logic [3:0]    meta_q, sync_q;
  logic [DW-1:0] dwell_q;
  logic [2:0]    col_q;
  logic [3:0]    samp0_q, samp1_q;
  logic [3:0]    cand_q, cnt_q;
  state_e        state_q;
  logic [3:0]    n_q;
  logic          v_q, ovr_q;

  logic          dwell_last, scan_end;
  logic [3:0]    res_d, cand_d, cnt_d;
  logic          is_key, qualified, event_d, release_d, accept, load, overrun;

  function automatic logic [1:0] row_of(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    if (r[1]) idx = 2'd1;
    if (r[2]) idx = 2'd2;
    if (r[3]) idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'd0;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b11_00: code = 4'd10;
      4'b11_01: code = 4'd0;
      4'b11_10: code = 4'd11;
      default:  code = 4'd0;
    endcase
    return code;
  endfunction

  assign dwell_last = (dwell_q == DWELL_LAST);
  assign scan_end   = dwell_last && col_q[2];

  // Column 2 is judged from the live synchronized value on its last dwell cycle
  always_comb begin
    res_d = RES_INVALID;
    if (samp0_q == 4'd0 && samp1_q == 4'd0 && sync_q == 4'd0)
      res_d = RES_NONE;
    else if ($onehot(samp0_q) && samp1_q == 4'd0 && sync_q == 4'd0)
      res_d = key_code(row_of(samp0_q), 2'd0);
    else if (samp0_q == 4'd0 && $onehot(samp1_q) && sync_q == 4'd0)
      res_d = key_code(row_of(samp1_q), 2'd1);
    else if (samp0_q == 4'd0 && samp1_q == 4'd0 && $onehot(sync_q))
      res_d = key_code(row_of(sync_q), 2'd2);
  end

  always_comb begin
    cand_d = res_d;
    cnt_d  = 4'd1;
    if (res_d == cand_q) begin
      cand_d = cand_q;
      cnt_d  = (cnt_q >= DB_MAX) ? cnt_q : cnt_q + 4'd1;
    end
  end

  assign is_key    = (cand_d < RES_NONE);
  assign qualified = (cnt_d == DB_MAX);
  assign event_d   = scan_end && (state_q == ST_RELEASED) && is_key && qualified;
  assign release_d = scan_end && (state_q == ST_PRESSED) && !is_key && qualified;
  assign accept    = v_q && ack;
  assign load      = event_d && (!v_q || ack);
  assign overrun   = event_d && v_q && !ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 4'd0;
      sync_q  <= 4'd0;
      dwell_q <= '0;
      col_q   <= 3'b001;
      samp0_q <= 4'd0;
      samp1_q <= 4'd0;
      cand_q  <= 4'd0;
      cnt_q   <= 4'd0;
      state_q <= ST_RELEASED;
      n_q     <= 4'd0;
      v_q     <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      meta_q <= R;
      sync_q <= meta_q;

      if (dwell_last) begin
        dwell_q <= '0;
        col_q   <= {col_q[1:0], col_q[2]};
        if (col_q[0]) samp0_q <= sync_q;
        if (col_q[1]) samp1_q <= sync_q;
      end else begin
        dwell_q <= dwell_q + 1'b1;
      end

      if (scan_end) begin
        cand_q <= cand_d;
        cnt_q  <= cnt_d;
        if (event_d)
          state_q <= ST_PRESSED;
        else if (release_d)
          state_q <= ST_RELEASED;
      end

      if (load) begin
        n_q <= cand_d;
        v_q <= 1'b1;
      end else if (accept) begin
        v_q <= 1'b0;
      end

      if (overrun)
        ovr_q <= 1'b1;
      else if (accept)
        ovr_q <= 1'b0;
    end
  end

  assign C   = col_q;
  assign N   = n_q;
  assign V   = v_q;
  assign ovr = ovr_q;

endmodule

`default_nettype wire
